// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode values and control-unit state encoding shared by datapath, control and bench
package cpu_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;
endpackage

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer driving datapath strobes from (state, opcode)
module control_unit
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       mem_done,
  input  logic       stop,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       PCout,
  output logic       Zlowout,
  output logic       MDRout,
  output logic       PCin,
  output logic       IRin,
  output logic       MARin,
  output logic       MDRin,
  output logic       Yin,
  output logic       Zin,
  output logic       CONin,
  output logic       IncPC,
  output logic       Read,
  output logic       Write,
  output logic [4:0] alu_op,
  output logic       run
);
  state_t state, nxt;
  logic t1_wait;
  logic is_r, is_imm, is_mem;
  logic [4:0] imm_alu;
  assign is_r    = opcode >= OP_ADD && opcode <= OP_OR;
  assign is_imm  = opcode >= OP_ADDI && opcode <= OP_ORI;
  assign is_mem  = opcode == OP_LD || opcode == OP_ST;
  assign imm_alu = opcode == OP_ADDI ? OP_ADD : opcode == OP_ANDI ? OP_AND : OP_OR;
  // t1_wait marks repeat T1 cycles so the PC reload happens only once per fetch
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state   <= S_RESET;
      t1_wait <= 1'b0;
    end else begin
      state   <= nxt;
      t1_wait <= state == S_T1 && !mem_done;
    end
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, Zlowout, MDRout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC, Read, Write} = '0;
    alu_op = '0;
    nxt = state;
    run = state != S_RESET && state != S_HALT;
    case (state)
      S_RESET: nxt = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        nxt = stop ? S_HALT : S_T1;
      end
      S_T1: begin
        Zlowout = !t1_wait; PCin = !t1_wait; Read = 1'b1; MDRin = 1'b1;
        nxt = mem_done ? S_T2 : S_T1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        nxt = S_T3;
      end
      S_T3: begin
        nxt = S_T0;
        if (is_r || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; nxt = S_T4;
        end else if (is_mem || opcode == OP_LDI) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; nxt = S_T4;
        end else if (opcode == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; nxt = S_T4;
        end else if (opcode == OP_JR) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (opcode == OP_HALT)
          nxt = S_HALT;
      end
      S_T4: begin
        nxt = S_T5;
        if (is_r) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu;
        end else if (is_mem || opcode == OP_LDI) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else if (opcode == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else
          nxt = S_T0;
      end
      S_T5: begin
        nxt = S_T0;
        if (is_r || is_imm || opcode == OP_LDI) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mem) begin
          Zlowout = 1'b1; MARin = 1'b1; nxt = S_T6;
        end else if (opcode == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; nxt = S_T6;
        end
      end
      S_T6: begin
        nxt = S_T0;
        if (opcode == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1; nxt = mem_done ? S_T7 : S_T6;
        end else if (opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; nxt = S_T7;
        end else if (opcode == OP_BR) begin
          Zlowout = con_ff; PCin = con_ff;
        end
      end
      S_T7: begin
        nxt = S_T0;
        if (opcode == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          Write = 1'b1; nxt = mem_done ? S_T0 : S_T7;
        end
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams checked against a per-instruction microstep table
module tb_control_unit;
  import cpu_pkg::*;
  typedef logic [25:0] vec_t;
  localparam vec_t RUN     = 26'h1 << 5;
  localparam vec_t WRITE   = 26'h1 << 6;
  localparam vec_t READ    = 26'h1 << 7;
  localparam vec_t INCPC   = 26'h1 << 8;
  localparam vec_t CONIN   = 26'h1 << 9;
  localparam vec_t ZIN     = 26'h1 << 10;
  localparam vec_t YIN     = 26'h1 << 11;
  localparam vec_t MDRIN   = 26'h1 << 12;
  localparam vec_t MARIN   = 26'h1 << 13;
  localparam vec_t IRIN    = 26'h1 << 14;
  localparam vec_t PCIN    = 26'h1 << 15;
  localparam vec_t MDROUT  = 26'h1 << 16;
  localparam vec_t ZLOWOUT = 26'h1 << 17;
  localparam vec_t PCOUT   = 26'h1 << 18;
  localparam vec_t COUT    = 26'h1 << 19;
  localparam vec_t BAOUT   = 26'h1 << 20;
  localparam vec_t ROUT    = 26'h1 << 21;
  localparam vec_t RIN     = 26'h1 << 22;
  localparam vec_t GRC     = 26'h1 << 23;
  localparam vec_t GRB     = 26'h1 << 24;
  localparam vec_t GRA     = 26'h1 << 25;
  logic clock, reset_n, con_ff, mem_done, stop;
  logic [4:0] opcode, alu_op;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, Zlowout, MDRout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC, Read, Write, run;
  vec_t obs;
  int total = 0, bad = 0;
  vec_t eq[$];
  bit mq[$];
  control_unit dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .con_ff(con_ff),
    .mem_done(mem_done), .stop(stop), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .PCout(PCout),
    .Zlowout(Zlowout), .MDRout(MDRout), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .CONin(CONin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );
  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, Zlowout, MDRout,
                PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC, Read, Write, run, alu_op};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic vec_t alu(input logic [4:0] op);
    return {21'b0, op};
  endfunction
  function automatic void put(input vec_t v, input bit m);
    eq.push_back(v | RUN);
    mq.push_back(m);
  endfunction
  // Expected per-cycle strobes for one whole instruction, fetch included, with memory wait counts
  function automatic void plan(input logic [4:0] op, input int w1, input int w6, input int w7, input logic con);
    eq.delete();
    mq.delete();
    put(PCOUT | MARIN | INCPC | ZIN, 1'($urandom));
    for (int i = 0; i <= w1; i++) put(READ | MDRIN | (i == 0 ? ZLOWOUT | PCIN : '0), i == w1);
    put(MDROUT | IRIN, 1'($urandom));
    if (op >= OP_ADD && op <= OP_OR) begin
      put(GRB | ROUT | YIN, 1'($urandom));
      put(GRC | ROUT | ZIN | alu(op), 1'($urandom));
      put(ZLOWOUT | GRA | RIN, 1'($urandom));
    end else if (op >= OP_ADDI && op <= OP_ORI) begin
      put(GRB | ROUT | YIN, 1'($urandom));
      put(COUT | ZIN | alu(op == OP_ADDI ? OP_ADD : op == OP_ANDI ? OP_AND : OP_OR), 1'($urandom));
      put(ZLOWOUT | GRA | RIN, 1'($urandom));
    end else if (op == OP_LDI || op == OP_LD || op == OP_ST) begin
      put(GRB | BAOUT | YIN, 1'($urandom));
      put(COUT | ZIN | alu(OP_ADD), 1'($urandom));
      if (op == OP_LDI) put(ZLOWOUT | GRA | RIN, 1'($urandom));
      else begin
        put(ZLOWOUT | MARIN, 1'($urandom));
        if (op == OP_LD) begin
          for (int i = 0; i <= w6; i++) put(READ | MDRIN, i == w6);
          put(MDROUT | GRA | RIN, 1'($urandom));
        end else begin
          put(GRA | ROUT | MDRIN, 1'($urandom));
          for (int i = 0; i <= w7; i++) put(WRITE, i == w7);
        end
      end
    end else if (op == OP_BR) begin
      put(GRA | ROUT | CONIN, 1'($urandom));
      put(PCOUT | YIN, 1'($urandom));
      put(COUT | ZIN | alu(OP_ADD), 1'($urandom));
      put(con ? ZLOWOUT | PCIN : '0, 1'($urandom));
    end else if (op == OP_JR) put(GRA | ROUT | PCIN, 1'($urandom));
    else put('0, 1'($urandom));
  endfunction
  task automatic run_instr(input logic [4:0] op, input int w1, input int w6, input int w7,
                           input logic con, input string name);
    plan(op, w1, w6, w7, con);
    for (int k = 0; k < eq.size(); k++) begin
      mem_done = mq[k];
      opcode = k < w1 + 3 ? 5'($urandom) : op;
      con_ff = k >= w1 + 4 ? con : 1'($urandom);
      stop = k == 0 ? 1'b0 : 1'($urandom);
      @(negedge clock);
      total++;
      if (obs !== eq[k]) begin
        bad++;
        $display("FAIL %s op=%b cycle %0d: got %h want %h", name, op, k, obs, eq[k]);
      end
      @(posedge clock); #1;
    end
  endtask
  task automatic test_reset;
    reset_n = 1'b0; stop = 1'b0; mem_done = 1'b1; opcode = OP_ADD; con_ff = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", obs); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_state: got %h want 0", obs); end
    @(posedge clock); #1;
  endtask
  task automatic test_reset_pulse(input string name);
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL %s async: got %h want 0", name, obs); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL %s reset_state: got %h want 0", name, obs); end
    @(posedge clock); #1;
    run_instr(OP_NOP, 0, 0, 0, 1'b0, {name, "_restart"});
  endtask
  task automatic test_halted(input string name);
    for (int i = 0; i < 20; i++) begin
      stop = 1'($urandom); mem_done = 1'($urandom); opcode = 5'($urandom); con_ff = 1'($urandom);
      @(negedge clock);
      total++;
      if (obs !== '0) begin bad++; $display("FAIL %s cycle %0d: got %h want 0", name, i, obs); end
      @(posedge clock); #1;
    end
  endtask
  task automatic test_directed;
    run_instr(OP_ADD, 0, 0, 0, 1'b0, "add_zero_wait");
    run_instr(OP_LD, 0, 2, 0, 1'b0, "ld_wait2");
    run_instr(OP_BR, 0, 0, 0, 1'b0, "br_not_taken");
    run_instr(OP_BR, 0, 0, 0, 1'b1, "br_taken");
    run_instr(OP_ST, 1, 0, 2, 1'b0, "st_wait");
    run_instr(OP_ORI, 0, 0, 0, 1'b0, "ori");
    run_instr(OP_JR, 2, 0, 0, 1'b0, "jr");
  endtask
  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == OP_HALT) op = OP_NOP;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), "random");
    end
  endtask
  task automatic test_halt_op;
    run_instr(OP_HALT, 0, 0, 0, 1'b0, "halt_op");
    test_halted("halt_op_held");
    test_reset_pulse("halt_op_exit");
  endtask
  task automatic test_stop;
    stop = 1'b1; mem_done = 1'b1;
    @(negedge clock);
    total++;
    if (obs !== (PCOUT | MARIN | INCPC | ZIN | RUN)) begin
      bad++; $display("FAIL stop_t0: got %h want %h", obs, PCOUT | MARIN | INCPC | ZIN | RUN);
    end
    @(posedge clock); #1;
    test_halted("stop_held");
    test_reset_pulse("stop_exit");
  endtask
  task automatic test_reset_mid_wait;
    stop = 1'b0; mem_done = 1'b0;
    @(negedge clock);
    total++;
    if (obs !== (PCOUT | MARIN | INCPC | ZIN | RUN)) begin
      bad++; $display("FAIL midwait_t0: got %h want %h", obs, PCOUT | MARIN | INCPC | ZIN | RUN);
    end
    @(posedge clock); #1;
    @(negedge clock);
    total++;
    if (obs !== (READ | MDRIN | ZLOWOUT | PCIN | RUN)) begin
      bad++; $display("FAIL midwait_t1: got %h want %h", obs, READ | MDRIN | ZLOWOUT | PCIN | RUN);
    end
    @(posedge clock); #1;
    @(negedge clock);
    total++;
    if (obs !== (READ | MDRIN | RUN)) begin
      bad++; $display("FAIL midwait_t1_hold: got %h want %h", obs, READ | MDRIN | RUN);
    end
    #2;
    test_reset_pulse("midwait_reset");
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_halt_op();
    test_stop();
    test_reset_mid_wait();
    run_instr(OP_SUB, 1, 0, 0, 1'b0, "after_midwait");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired multi-cycle control unit for the 32-bit datapath. It sequences fetch, decode and execute, and drives the register select/encode stage through Gra/Grb/Grc/Rin/Rout/BAout/Cout. It also drives bus-source, register-enable, ALU-op and memory strobes. It consumes the 5-bit opcode from IR[31:27] and the CON flip-flop result.

## Interface
- No parameters. Opcode and state constants come from `cpu_pkg`.
- `clock`  in  1  system clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  5  IR[31:27]; valid from state T3 onward.
- `con_ff`  in  1  branch condition; valid from T4 onward.
- `mem_done`  in  1  memory handshake complete; may rise in the same cycle as Read/Write.
- `stop`  in  1  halt request; sampled only in T0.
- `Gra, Grb, Grc, Rin, Rout, BAout, Cout`  out  1 each  register select/encode controls.
- `PCout, Zlowout, MDRout`  out  1 each  bus sources.
- `PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC`  out  1 each  register enables.
- `Read, Write`  out  1 each  memory strobes.
- `alu_op`  out  5  ALU operation, encoded with opcode values.
- `run`  out  1  high while executing; low in RESET and HALT.

## Operation
- Registered state; all outputs are combinational decode of (state, opcode). Outputs not listed for a state are 0. `alu_op` is 0 unless Zin=1.
- States: RESET, T0–T7, HALT.
- **RESET**: all outputs 0, run=0. The cycle after reset_n deasserts, advance to T0.
- **T0**: PCout, MARin, IncPC, Zin. Next state is HALT if stop=1, else T1.
- **T1**: Zlowout, PCin, Read, MDRin.
  - PCin and Zlowout are asserted only on the first T1 cycle.
  - Read and MDRin are held until mem_done=1, then advance to T2.
- **T2**: MDRout, IRin. Advance to T3.
- **ALU R-type** (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin. Return to T0.
- **Immediate** (addi 01011, andi 01100, ori 01101): same as R-type, except T4 uses Cout in place of Grc+Rout, and alu_op = add/and/or respectively.
- **ldi 00001**:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin. Return to T0.
- **ld 00000**:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin, held until mem_done.
  - T7: MDRout, Gra, Rin. Return to T0.
- **st 00010**:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write, held until mem_done. Return to T0.
- **br 10010**:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, alu_op=00011.
  - T6: if con_ff=1, Zlowout and PCin; otherwise nothing. Return to T0.
- **jr 10011**: T3: Gra, Rout, PCin. Return to T0.
- **nop 11001** and every unlisted opcode: T3 asserts nothing. Return to T0.
- **halt 11010**: T3 → HALT.
- **HALT**: all outputs 0, run=0. Exits only through reset_n.

## Timing
- Zero-wait memory (mem_done high in the same cycle as the strobe) gives these instruction lengths:
  - jr, nop, halt: 4 cycles.
  - ALU, immediate, ldi: 6 cycles.
  - br: 7 cycles.
  - ld, st: 8 cycles.
- Each cycle that mem_done stays low adds one cycle in T1/T6/T7.
- mem_done outside a Read/Write state is ignored.
- reset_n low in any state forces RESET immediately, and outputs go to 0 asynchronously, including mid memory wait.
- stop is ignored outside T0. If stop and reset_n are low together, reset wins.

## Structure
- `cpu_pkg` holds the 5-bit opcode localparams and the state encoding (4-bit). The ALU and testbench share these constants.
- Single module, no sub-module: one always_ff for the state register and one always_comb for next-state and output decode.

## Test plan
- Reset released, mem_done tied 1, opcode=00011 → states RESET, T0, T1, T2, T3, T4, T5, T0. T4 shows Grc=Rout=Zin=1 and alu_op=00011. T5 shows Gra=Rin=1.
- ld (00000) with mem_done low for 2 cycles in T6 → Read=MDRin=1 for exactly 3 cycles. T7 shows MDRout, Gra, Rin. Total 10 cycles.
- br (10010): con_ff=0 → PCin stays 0 in T6. con_ff=1 → Zlowout=PCin=1 in T6.
- st (00010) → T6 shows Gra, Rout, MDRin. T7 shows Write=1 until mem_done. Read is never asserted after T1.
- Opcode 11010, and separately stop=1 in T0 → HALT with run=0 and all outputs 0 for 20 cycles. reset_n pulse → RESET then T0.
- reset_n asserted during a T1 wait → all outputs 0 immediately. After release, fetch restarts in T0.
